des_key_schedule: RTL and testbench
===================================

Name: des_key_schedule

Overview:
Upstream feeder for the DES datapath. It replaces the fixed 48-bit round key with the real DES key schedule. The block takes a 64-bit key and applies PC-1. It then produces the 16 round subkeys K1..K16 one per round; decrypt mode gives them in reverse order, K16..K1. Each subkey is PC-2 of the rotated C/D halves and drives the round function's key_dat input, in step with the round counter.

Parameters:
AUTO_ADV, 0, 1 = advance one round every cycle once valid, and ignore adv (free-running round counter); 0 = advance only on adv.

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  synchronous reset, active-high
key_in  input  64  DES key; bit 1 (FIPS numbering) = key_in[63]; parity bits 8,16,..,64 ignored
key_load  input  1  one-cycle request to capture key_in and start a schedule
decrypt  input  1  sampled with key_load; 1 = emit K16 first and rotate right
adv  input  1  consumer has used the current subkey; step to the next round
subkey  output  48  current round subkey; bit 1 of PC-2 output = subkey[47]
round  output  4  index of the current subkey in emission order, 0..15
subkey_valid  output  1  subkey/round are meaningful
done  output  1  one-cycle pulse after the last subkey is consumed
busy  output  1  schedule in progress (subkey_valid or done)

Behaviour:
- State: C[28], D[28], round[4], FSM {IDLE, RUN, DONE}.
- subkey = PC-2(C,D), combinational from registers only; no path from inputs to outputs.
- Reset (rst=1 at a clock edge, any state including mid-schedule): FSM=IDLE, C=D=0, round=0, subkey_valid=0, done=0, busy=0. subkey then reads PC-2(0)=0.
- IDLE, key_load=1 at edge t: {C,D} = PC-1(key_in), then a first adjustment, then FSM=RUN, round=0.
  - Encrypt first adjustment: rotl 1.
  - Decrypt first adjustment: none (28 total shifts return C/D to PC-1; that gives K16).
  - From cycle t+1: subkey_valid=1, subkey=K1 (enc) or K16 (dec).
- RUN, step condition = adv (or 1 when AUTO_ADV=1):
  - round<15 with step: round+1. Shift C and D by s(n), where n = next round number in encrypt order.
  - Encrypt shift is rotl; s=1 for n in {1,2,9,16}, else 2.
  - Decrypt shift is rotr; decrypt step j (0..14) uses s of encrypt round 16-j. Equivalently: 1 for j=0,7,14; 2 otherwise.
  - round=15 with step: FSM=DONE, subkey_valid=0.
  - No step: hold all state; subkey stays stable indefinitely.
- DONE: done=1, busy=1 for exactly one cycle, then IDLE. done and subkey_valid are never 1 together.
- key_load while RUN or DONE aborts the current schedule and restarts exactly as from IDLE, with the new key and decrypt value. key_load has priority over a simultaneous adv, and done is not pulsed for the aborted run.
- adv in IDLE or DONE: ignored.
- decrypt and key_in are sampled only on an accepted key_load; later changes have no effect.
- After round 15 in encrypt mode the cumulative rotation is 28, so C/D equal PC-1(key) again. In decrypt mode the final subkey is K1.
- Throughput: 16 subkeys in 16 consecutive cycles when adv is held high; done appears on the 17th cycle after load.
- Latency: key_load edge to first valid subkey is 1 cycle.

Test Plan:
1. Reset, then key_in=64'h133457799BBCDFF1, key_load=1, decrypt=0, adv=0 → next cycle subkey_valid=1, round=0, subkey=48'h1B02EFFC7072, busy=1; value held for 10 cycles with adv=0.
2. Continuing scenario 1, pulse adv once → round=1, subkey=48'h79AED9DBC9E5. Hold adv=1 → round=15, subkey=48'hCB3D8B0E17F5. Next adv → done=1 for 1 cycle, subkey_valid=0; following cycle busy=0.
3. Same key with decrypt=1 and adv held high → round0 subkey=48'hCB3D8B0E17F5, round15 subkey=48'h1B02EFFC7072. Full 16-entry sequence equals the reverse of the encrypt sequence; done is asserted on the 17th cycle.
4. Encrypt load, advance to round=7, then assert key_load with key_in=64'h0 → next cycle round=0, subkey=48'h0, no done pulse. Same test with rst=1 at round 7 → all outputs 0 next cycle.
5. AUTO_ADV=1 with adv tied 0 → 16 consecutive distinct subkeys matching the scenario-2 sequence, then done.
6. Flip parity bits only (key_in ^ 64'h0101010101010101) → identical subkey sequence. Also assert adv while IDLE → no state change, subkey_valid stays 0.

Source files
------------

// File: rtl/des_key_schedule.sv
// DES key schedule.
//
// Captures a 64-bit DES key, applies PC-1 and then emits the sixteen 48-bit
// round subkeys one per round (K1..K16 for encrypt, K16..K1 for decrypt).
// Each subkey is PC-2 of the current C/D halves and comes from registers only.
//
// Parameters:
//   AUTO_ADV     1 = step every cycle while running, adv ignored; 0 = step on adv
// Ports:
//   clk          system clock, all state on rising edge
//   rst          synchronous reset, active-high
//   key_in       DES key, FIPS bit 1 = key_in[63]; parity bits are never used
//   key_load     capture key_in/decrypt and (re)start a schedule
//   decrypt      sampled with key_load; 1 = emit K16 first, rotate right
//   adv          consumer used the current subkey; step to the next round
//   subkey       current round subkey, PC-2 bit 1 = subkey[47]
//   round        emission index of the current subkey, 0..15
//   subkey_valid subkey/round are meaningful
//   done         one-cycle pulse after the last subkey is consumed
//   busy         schedule in progress (subkey_valid or done)

module des_key_schedule #(
  parameter int unsigned AUTO_ADV = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] key_in,
  input  logic        key_load,
  input  logic        decrypt,
  input  logic        adv,
  output logic [47:0] subkey,
  output logic [3:0]  round,
  output logic        subkey_valid,
  output logic        done,
  output logic        busy
);

  // Permuted choice 1, FIPS bit numbers of the key selected for C1..C28,D1..D28.
  localparam int unsigned Pc1Tab [56] = '{
    57, 49, 41, 33, 25, 17,  9,
     1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27,
    19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,
     7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29,
    21, 13,  5, 28, 20, 12,  4
  };

  // Permuted choice 2, bit numbers of the 56-bit C||D selected for subkey bits 1..48.
  localparam int unsigned Pc2Tab [48] = '{
    14, 17, 11, 24,  1,  5,
     3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8,
    16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55,
    30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53,
    46, 42, 50, 36, 29, 32
  };

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  function automatic logic [55:0] pc1(input logic [63:0] k);
    logic [55:0] o;
    o = '0;
    for (int i = 0; i < 56; i++) begin
      o[6'(55 - i)] = k[6'(64 - Pc1Tab[i])];
    end
    return o;
  endfunction

  function automatic logic [47:0] pc2(input logic [55:0] cd);
    logic [47:0] o;
    o = '0;
    for (int i = 0; i < 48; i++) begin
      o[6'(47 - i)] = cd[6'(56 - Pc2Tab[i])];
    end
    return o;
  endfunction

  // Bit 1 of a half is its MSB, so rotl moves the MSB to the LSB.
  function automatic logic [27:0] rotl(input logic [27:0] v, input logic two);
    return two ? {v[25:0], v[27:26]} : {v[26:0], v[27]};
  endfunction

  function automatic logic [27:0] rotr(input logic [27:0] v, input logic two);
    return two ? {v[1:0], v[27:2]} : {v[0], v[27:1]};
  endfunction

  state_e      state_q, state_d;
  logic [27:0] c_q, c_d;
  logic [27:0] d_q, d_d;
  logic [3:0]  round_q, round_d;
  logic        dec_q, dec_d;

  logic [55:0] load_cd;
  logic        step;
  logic        two_shift;

  assign load_cd = pc1(key_in);
  assign step    = (AUTO_ADV != 0) || adv;

  // Leaving emission index 0, 7 or 14 is a single-bit shift in both directions:
  // encrypt enters rounds 2, 9, 16 and decrypt mirrors the same schedule.
  assign two_shift = !((round_q == 4'd0) || (round_q == 4'd7) || (round_q == 4'd14));

  always_comb begin
    state_d = state_q;
    c_d     = c_q;
    d_d     = d_q;
    round_d = round_q;
    dec_d   = dec_q;
    if (key_load) begin
      // Decrypt starts unrotated: a full 28-shift schedule lands back on PC-1, i.e. K16.
      c_d     = decrypt ? load_cd[55:28] : rotl(load_cd[55:28], 1'b0);
      d_d     = decrypt ? load_cd[27:0]  : rotl(load_cd[27:0], 1'b0);
      dec_d   = decrypt;
      round_d = 4'd0;
      state_d = StRun;
    end else begin
      unique case (state_q)
        StIdle: begin
        end
        StRun: begin
          if (step) begin
            if (round_q == 4'd15) begin
              state_d = StDone;
            end else begin
              round_d = round_q + 4'd1;
              c_d     = dec_q ? rotr(c_q, two_shift) : rotl(c_q, two_shift);
              d_d     = dec_q ? rotr(d_q, two_shift) : rotl(d_q, two_shift);
            end
          end
        end
        StDone: begin
          state_d = StIdle;
        end
        default: begin
          state_d = StIdle;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      c_q     <= '0;
      d_q     <= '0;
      round_q <= '0;
      dec_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      c_q     <= c_d;
      d_q     <= d_d;
      round_q <= round_d;
      dec_q   <= dec_d;
    end
  end

  assign subkey       = pc2({c_q, d_q});
  assign round        = round_q;
  assign subkey_valid = (state_q == StRun);
  assign done         = (state_q == StDone);
  assign busy         = (state_q != StIdle);

endmodule

// File: tb/tb_des_key_schedule.sv
module tb_des_key_schedule;

  localparam logic [63:0] KeyA   = 64'h133457799BBCDFF1;
  localparam logic [63:0] Parity = 64'h0101010101010101;
  localparam logic [47:0] KeyA1  = 48'h1B02EFFC7072;
  localparam logic [47:0] KeyA2  = 48'h79AED9DBC9E5;
  localparam logic [47:0] KeyA16 = 48'hCB3D8B0E17F5;

  localparam int Pc1T [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };
  localparam int Pc2T [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };
  localparam int Shifts [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

  logic        clk;
  logic        rst;
  logic [63:0] key_in;
  logic        decrypt;
  logic        key_load0, adv0, key_load1, adv1;
  logic [47:0] sk0, sk1;
  logic [3:0]  r0, r1;
  logic        v0, v1, d0, d1, b0, b1;

  int checks = 0;
  int errors = 0;
  bit mon_en = 0;

  // Entry: [52] done, [51:48] round, [47:0] subkey
  logic [52:0] q0[$];
  logic [52:0] q1[$];

  int                 st0 = 0, idx0 = 0, st1 = 0, idx1 = 0;
  bit                 dec0 = 0, dec1 = 0;
  logic [15:0][47:0]  ks0, ks1;

  des_key_schedule #(.AUTO_ADV(0)) dut0 (
    .clk(clk), .rst(rst), .key_in(key_in), .key_load(key_load0), .decrypt(decrypt),
    .adv(adv0), .subkey(sk0), .round(r0), .subkey_valid(v0), .done(d0), .busy(b0)
  );

  des_key_schedule #(.AUTO_ADV(1)) dut1 (
    .clk(clk), .rst(rst), .key_in(key_in), .key_load(key_load1), .decrypt(decrypt),
    .adv(adv1), .subkey(sk1), .round(r1), .subkey_valid(v1), .done(d1), .busy(b1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endfunction

  // Reference schedule: rotate the PC-1 halves by the cumulative shift count of each round.
  function automatic logic [15:0][47:0] ref_subkeys(input logic [63:0] key);
    logic [55:0]       cd;
    logic [55:0]       tc, td, rcd;
    logic [27:0]       c, d;
    int                cum;
    logic [15:0][47:0] ks;
    for (int i = 0; i < 56; i++) cd[6'(55 - i)] = key[6'(64 - Pc1T[i])];
    cum = 0;
    for (int r = 0; r < 16; r++) begin
      cum = cum + Shifts[r];
      tc  = {cd[55:28], cd[55:28]};
      td  = {cd[27:0], cd[27:0]};
      c   = tc[(55 - (cum % 28)) -: 28];
      d   = td[(55 - (cum % 28)) -: 28];
      rcd = {c, d};
      for (int j = 0; j < 48; j++) ks[r][6'(47 - j)] = rcd[6'(56 - Pc2T[j])];
    end
    return ks;
  endfunction

  // Behavioural model: st 0 idle, 1 emitting, 2 done pulse.
  function automatic void mstep(input bit r, input bit ld, input bit dc, input bit stp,
                                input logic [63:0] k, inout int st, inout int idx, inout bit dec,
                                inout logic [15:0][47:0] ks, output bit push,
                                output logic [52:0] ent);
    if (r) st = 0;
    else if (ld) begin
      ks  = ref_subkeys(k);
      dec = dc;
      idx = 0;
      st  = 1;
    end else if (st == 1) begin
      if (stp) begin
        if (idx == 15) st = 2;
        else idx++;
      end
    end else if (st == 2) st = 0;
    push = (st != 0);
    if (st == 2) ent = {1'b1, 4'd0, 48'd0};
    else ent = {1'b0, 4'(idx), dec ? ks[4'(15 - idx)] : ks[4'(idx)]};
  endfunction

  task automatic tick();
    bit          p;
    logic [52:0] e;
    @(posedge clk);
    mstep(rst, key_load0, decrypt, adv0, key_in, st0, idx0, dec0, ks0, p, e);
    if (p) q0.push_back(e);
    mstep(rst, key_load1, decrypt, 1'b1, key_in, st1, idx1, dec1, ks1, p, e);
    if (p) q1.push_back(e);
    #1;
  endtask

  always @(negedge clk) begin
    logic [52:0] e;
    if (mon_en) begin
      if (v0 || d0) begin
        if (q0.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL dut0_unexpected valid=%0b done=%0b required=idle", v0, d0);
        end else begin
          e = q0.pop_front();
          chk("dut0_flags", {v0, d0, b0}, {~e[52], e[52], 1'b1});
          if (!e[52]) begin
            chk("dut0_round", r0, e[51:48]);
            chk("dut0_subkey", sk0, e[47:0]);
          end
        end
      end else chk("dut0_idle_busy", b0, 0);
      if (v1 || d1) begin
        if (q1.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL dut1_unexpected valid=%0b done=%0b required=idle", v1, d1);
        end else begin
          e = q1.pop_front();
          chk("dut1_flags", {v1, d1, b1}, {~e[52], e[52], 1'b1});
          if (!e[52]) begin
            chk("dut1_round", r1, e[51:48]);
            chk("dut1_subkey", sk1, e[47:0]);
          end
        end
      end else chk("dut1_idle_busy", b1, 0);
    end
  end

  initial begin
    rst = 1; key_in = '0; decrypt = 0;
    key_load0 = 0; adv0 = 0; key_load1 = 0; adv1 = 0;
    tick();
    mon_en = 1;
    tick();
    chk("reset_subkey", sk0, 0);
    chk("reset_round", r0, 0);
    chk("reset_valid", v0, 0);
    rst = 0;

    // adv while idle changes nothing
    adv0 = 1;
    repeat (3) tick();
    chk("idle_adv_valid", v0, 0);
    adv0 = 0;

    // Encrypt load, hold without adv
    key_in = KeyA; key_load0 = 1;
    tick();
    key_load0 = 0;
    chk("enc_k1", sk0, KeyA1);
    chk("enc_r0", r0, 0);
    repeat (10) tick();
    chk("enc_k1_hold", sk0, KeyA1);

    // Single step, then run through to done
    adv0 = 1;
    tick();
    adv0 = 0;
    chk("enc_k2", sk0, KeyA2);
    tick();
    adv0 = 1;
    repeat (14) tick();
    chk("enc_k16", sk0, KeyA16);
    chk("enc_r15", r0, 15);
    tick();
    chk("enc_done", d0, 1);
    tick();
    chk("enc_busy_after", b0, 0);
    adv0 = 0;

    // Decrypt with adv high; load wins over simultaneous adv
    decrypt = 1; key_load0 = 1; adv0 = 1;
    tick();
    key_load0 = 0; decrypt = 0;
    chk("dec_first", sk0, KeyA16);
    repeat (15) tick();
    chk("dec_last", sk0, KeyA1);
    tick();
    chk("dec_done", d0, 1);
    tick();
    adv0 = 0;

    // Abort at round 7 with a zero key
    key_in = KeyA; key_load0 = 1;
    tick();
    key_load0 = 0; adv0 = 1;
    repeat (7) tick();
    chk("abort_r7", r0, 7);
    key_in = '0; key_load0 = 1;
    tick();
    key_load0 = 0; adv0 = 0;
    chk("abort_r0", r0, 0);
    chk("abort_sk0", sk0, 0);
    repeat (3) tick();

    // Reset at round 7
    key_in = KeyA; key_load0 = 1;
    tick();
    key_load0 = 0; adv0 = 1;
    repeat (7) tick();
    adv0 = 0; rst = 1;
    tick();
    rst = 0;
    chk("rst_mid_sk", sk0, 0);
    chk("rst_mid_round", r0, 0);
    chk("rst_mid_valid", v0, 0);

    // Free-running instance, adv tied low
    key_in = KeyA; key_load1 = 1;
    tick();
    key_load1 = 0;
    chk("auto_k1", sk1, KeyA1);
    tick();
    chk("auto_k2", sk1, KeyA2);
    repeat (18) tick();

    // Parity bits do not matter
    key_in = KeyA ^ Parity; key_load0 = 1; adv0 = 1;
    tick();
    key_load0 = 0;
    chk("parity_k1", sk0, KeyA1);
    tick();
    chk("parity_k2", sk0, KeyA2);
    repeat (17) tick();
    adv0 = 0;

    // Random traffic on both instances
    for (int i = 0; i < 600; i++) begin
      rst       = ($urandom_range(0, 149) == 0);
      key_load0 = ($urandom_range(0, 24) == 0);
      key_load1 = ($urandom_range(0, 29) == 0);
      decrypt   = 1'($urandom);
      adv0      = 1'($urandom);
      key_in    = {$urandom, $urandom};
      tick();
    end
    rst = 0; key_load0 = 0; key_load1 = 0; adv0 = 1;
    repeat (20) tick();
    @(negedge clk);
    #1;
    chk("q0_drained", q0.size(), 0);
    chk("q1_drained", q1.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
